// File: rtl/resize_bitpack_rx_if.sv
// Bundle of the resize-stream input, packed-word output and status signals.
interface resize_bitpack_rx_if #(
    parameter int unsigned WORD_W = 32
);
    logic              DIN_VALID;
    logic              DIN;
    logic              LAST_IN_LINE;
    logic              LAST_PIX;
    logic              SQUEEZE;
    logic              NEXT_LAST_PIX;
    logic [WORD_W-1:0] WORD_DATA;
    logic [5:0]        WORD_LEN;
    logic              WORD_LAST_LINE;
    logic              WORD_LAST_FRAME;
    logic              WORD_VALID;
    logic              WORD_READY;
    logic              SQUEEZE_LATCHED;
    logic [8:0]        LINE_CNT;
    logic [16:0]       FRAME_ONES;
    logic              OVERFLOW;

    // Upstream pixel source and downstream word consumer.
    modport master (
        output DIN_VALID, DIN, LAST_IN_LINE, LAST_PIX, SQUEEZE, WORD_READY,
        input  NEXT_LAST_PIX, WORD_DATA, WORD_LEN, WORD_LAST_LINE, WORD_LAST_FRAME,
        input  WORD_VALID, SQUEEZE_LATCHED, LINE_CNT, FRAME_ONES, OVERFLOW
    );

    // The receiver itself.
    modport slave (
        input  DIN_VALID, DIN, LAST_IN_LINE, LAST_PIX, SQUEEZE, WORD_READY,
        output NEXT_LAST_PIX, WORD_DATA, WORD_LEN, WORD_LAST_LINE, WORD_LAST_FRAME,
        output WORD_VALID, SQUEEZE_LATCHED, LINE_CNT, FRAME_ONES, OVERFLOW
    );
endinterface

// File: rtl/resize_bitpack_rx.sv
// Receiver for the binary resize stream: packs pixels LSB-first into words, closes a
// word at WORD_W bits or at any line end, and queues words in an FWFT FIFO. Signals
// frame completion upstream once the frame's final word has left the FIFO.
module resize_bitpack_rx #(
    parameter int unsigned WORD_W     = 32,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input logic                CLK,
    input logic                RST,
    resize_bitpack_rx_if.slave bus
);
    localparam int unsigned PtrW    = $clog2(FIFO_DEPTH);
    localparam logic [PtrW:0] FullCnt = (PtrW + 1)'(FIFO_DEPTH);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StRun   = 2'd1;
    localparam logic [1:0] StDrain = 2'd2;

    typedef struct packed {
        logic [WORD_W-1:0] data;
        logic [5:0]        len;
        logic              last_line;
        logic              last_frame;
    } word_t;

    logic [1:0]        state_q, state_d;
    logic [WORD_W-1:0] pack_q;
    logic [5:0]        bit_cnt_q;
    logic              squeeze_q, squeeze_d;
    logic [8:0]        line_q, line_d;
    logic [16:0]       ones_q, ones_d;
    logic [16:0]       fones_q, fones_d;
    logic              ovf_q, ovf_d;
    logic              nlp_q, nlp_d;
    logic              lf_drop_q, lf_drop_d;

    word_t             mem [FIFO_DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [PtrW:0]     count_q;

    logic              accept, line_end, close, full, valid, pop, push, drop;
    logic [WORD_W-1:0] pack_next;
    logic [5:0]        len_next;
    word_t             head, new_word;

    assign accept    = bus.DIN_VALID && (state_q != StDrain);
    assign line_end  = bus.LAST_IN_LINE | bus.LAST_PIX;
    assign pack_next = pack_q | ({{(WORD_W-1){1'b0}}, bus.DIN} << bit_cnt_q);
    assign len_next  = bit_cnt_q + 6'd1;
    assign close     = accept && ((len_next == 6'(WORD_W)) || line_end);

    assign valid = (count_q != '0);
    assign full  = (count_q == FullCnt);
    assign pop   = valid && bus.WORD_READY;
    // A pop in the same cycle frees the slot, so a full FIFO still takes the push.
    assign push  = close && (!full || pop);
    assign drop  = close && !push;
    assign head  = mem[rd_ptr_q];

    assign new_word = '{data: pack_next, len: len_next, last_line: line_end,
                        last_frame: bus.LAST_PIX};

    // Head fields are masked so an empty FIFO presents all-zero outputs.
    assign bus.WORD_VALID      = valid;
    assign bus.WORD_DATA       = valid ? head.data : '0;
    assign bus.WORD_LEN        = valid ? head.len : '0;
    assign bus.WORD_LAST_LINE  = valid & head.last_line;
    assign bus.WORD_LAST_FRAME = valid & head.last_frame;
    assign bus.NEXT_LAST_PIX   = nlp_q;
    assign bus.SQUEEZE_LATCHED = squeeze_q;
    assign bus.LINE_CNT        = line_q;
    assign bus.FRAME_ONES      = fones_q;
    assign bus.OVERFLOW        = ovf_q;

    // Frame state, per-frame counters and sticky overflow.
    always_comb begin
        state_d   = state_q;
        squeeze_d = squeeze_q;
        line_d    = line_q;
        ones_d    = ones_q;
        fones_d   = fones_q;
        ovf_d     = ovf_q;
        lf_drop_d = lf_drop_q;
        nlp_d     = 1'b0;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    squeeze_d = bus.SQUEEZE;
                    ones_d    = {16'd0, bus.DIN};
                    line_d    = {8'd0, line_end};
                    if (bus.LAST_PIX) begin
                        state_d = StDrain;
                        fones_d = {16'd0, bus.DIN};
                    end else begin
                        state_d = StRun;
                    end
                end
            end
            StRun: begin
                if (accept) begin
                    ones_d = ones_q + {16'd0, bus.DIN};
                    if (line_end && (line_q != 9'd511)) line_d = line_q + 9'd1;
                    if (bus.LAST_PIX) begin
                        state_d = StDrain;
                        fones_d = ones_q + {16'd0, bus.DIN};
                    end
                end
            end
            StDrain: begin
                if (bus.DIN_VALID) ovf_d = 1'b1;
                // If the frame's final word was dropped, an empty FIFO ends the frame.
                if ((pop && head.last_frame) || (lf_drop_q && !valid)) begin
                    state_d   = StIdle;
                    nlp_d     = 1'b1;
                    lf_drop_d = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
        if (drop) begin
            ovf_d = 1'b1;
            if (bus.LAST_PIX) lf_drop_d = 1'b1;
        end
    end

    // Control and status registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= StIdle;
            squeeze_q <= 1'b0;
            line_q    <= '0;
            ones_q    <= '0;
            fones_q   <= '0;
            ovf_q     <= 1'b0;
            nlp_q     <= 1'b0;
            lf_drop_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            squeeze_q <= squeeze_d;
            line_q    <= line_d;
            ones_q    <= ones_d;
            fones_q   <= fones_d;
            ovf_q     <= ovf_d;
            nlp_q     <= nlp_d;
            lf_drop_q <= lf_drop_d;
        end
    end

    // Bit packer: restarts empty after every closed word.
    always_ff @(posedge CLK) begin
        if (RST) begin
            pack_q    <= '0;
            bit_cnt_q <= '0;
        end else if (accept) begin
            if (close) begin
                pack_q    <= '0;
                bit_cnt_q <= '0;
            end else begin
                pack_q    <= pack_next;
                bit_cnt_q <= len_next;
            end
        end
    end

    // FIFO storage; contents need no reset since the head is masked when empty.
    always_ff @(posedge CLK) begin
        if (push) mem[wr_ptr_q] <= new_word;
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end
endmodule

// File: tb/tb_resize_bitpack_rx.sv
// Self-checking bench for resize_bitpack_rx: a queue-based frame model checked every
// cycle, plus directed frames with hand-computed word and status expectations.
module tb_resize_bitpack_rx;
    localparam int W     = 32;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    resize_bitpack_rx_if #(.WORD_W(W)) bus ();

    resize_bitpack_rx #(.WORD_W(W), .FIFO_DEPTH(DEPTH)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic [31:0] data;
        int          len;
        bit          ll;
        bit          lf;
    } word_t;

    int    checks = 0;
    int    errors = 0;
    bit    chk_en = 1'b0;
    word_t exp_q[$];
    word_t log_q[$];

    // Model state, expressed at frame/word level.
    typedef enum {MIdle, MRun, MDrain} mmode_t;
    mmode_t      m_mode   = MIdle;
    logic [31:0] m_bits   = '0;
    int          m_len    = 0;
    int          m_ones   = 0;
    int          m_line   = 0;
    int          m_fones  = 0;
    bit          m_sq     = 1'b0;
    bit          m_ovf    = 1'b0;
    bit          m_nlp    = 1'b0;
    bit          m_lfdrop = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance the model by one clock using the inputs applied this cycle.
    task automatic model_step();
        bit    pop, pop_lf, was_empty, full, close, lil, lp;
        word_t w;
        if (rst) begin
            exp_q.delete();
            m_mode = MIdle; m_bits = '0; m_len = 0; m_ones = 0; m_line = 0;
            m_fones = 0; m_sq = 0; m_ovf = 0; m_nlp = 0; m_lfdrop = 0;
            return;
        end
        lil       = bus.LAST_IN_LINE;
        lp        = bus.LAST_PIX;
        pop       = bus.WORD_READY && (exp_q.size() > 0);
        pop_lf    = pop && exp_q[0].lf;
        was_empty = (exp_q.size() == 0);
        full      = (exp_q.size() >= DEPTH);
        close     = 1'b0;
        m_nlp     = 1'b0;
        if (m_mode == MDrain) begin
            if (bus.DIN_VALID) m_ovf = 1'b1;
            if (pop_lf || (m_lfdrop && was_empty)) begin
                m_mode = MIdle; m_nlp = 1'b1; m_lfdrop = 1'b0;
            end
        end else if (bus.DIN_VALID) begin
            if (m_mode == MIdle) begin
                m_sq   = bus.SQUEEZE;
                m_ones = int'(bus.DIN);
                m_line = (lil || lp) ? 1 : 0;
            end else begin
                m_ones += int'(bus.DIN);
                if ((lil || lp) && m_line < 511) m_line++;
            end
            if (lp) begin
                m_fones = m_ones; m_mode = MDrain;
            end else begin
                m_mode = MRun;
            end
            m_bits[m_len] = bus.DIN;
            m_len++;
            if (m_len == W || lil || lp) begin
                close = 1'b1;
                w = '{data: m_bits, len: m_len, ll: (lil || lp), lf: lp};
                m_bits = '0; m_len = 0;
            end
        end
        if (pop) void'(exp_q.pop_front());
        if (close) begin
            if (!full || pop) exp_q.push_back(w);
            else begin
                m_ovf = 1'b1;
                if (lp) m_lfdrop = 1'b1;
            end
        end
    endtask

    // Compare process: check outputs against the model, log pops, then step the model.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("word_valid", bus.WORD_VALID, (exp_q.size() > 0));
                if (exp_q.size() > 0) begin
                    check("word_data", bus.WORD_DATA, exp_q[0].data);
                    check("word_len", bus.WORD_LEN, exp_q[0].len);
                    check("word_last_line", bus.WORD_LAST_LINE, exp_q[0].ll);
                    check("word_last_frame", bus.WORD_LAST_FRAME, exp_q[0].lf);
                end
                check("next_last_pix", bus.NEXT_LAST_PIX, m_nlp);
                check("squeeze_latched", bus.SQUEEZE_LATCHED, m_sq);
                check("line_cnt", bus.LINE_CNT, m_line);
                check("frame_ones", bus.FRAME_ONES, m_fones);
                check("overflow", bus.OVERFLOW, m_ovf);
                if (bus.WORD_VALID && bus.WORD_READY && !rst)
                    log_q.push_back('{data: bus.WORD_DATA, len: bus.WORD_LEN,
                                      ll: bus.WORD_LAST_LINE, lf: bus.WORD_LAST_FRAME});
            end
            model_step();
        end
    end

    // One pixel for one cycle; returns 1 time unit after the sampling edge.
    task automatic pix(input bit d, input bit lil, input bit lp);
        bus.DIN_VALID = 1'b1; bus.DIN = d; bus.LAST_IN_LINE = lil; bus.LAST_PIX = lp;
        @(posedge clk); #1;
        bus.DIN_VALID = 1'b0; bus.DIN = 1'b0; bus.LAST_IN_LINE = 1'b0; bus.LAST_PIX = 1'b0;
    endtask

    task automatic wait_nlp(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (bus.NEXT_LAST_PIX) seen = 1'b1;
        end
        check(name, seen, 1'b1);
        @(posedge clk); #1;
    endtask

    task automatic check_word(input string name, input int idx, input logic [31:0] data,
                              input int len, input bit ll, input bit lf);
        if (idx < log_q.size()) begin
            check({name, " data"}, log_q[idx].data, data);
            check({name, " len"}, log_q[idx].len, len);
            check({name, " last_line"}, log_q[idx].ll, ll);
            check({name, " last_frame"}, log_q[idx].lf, lf);
        end else begin
            check({name, " present"}, log_q.size(), idx + 1);
        end
    endtask

    task automatic reset_pulse();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    logic [7:0] pat;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        bus.DIN_VALID = 0; bus.DIN = 0; bus.LAST_IN_LINE = 0; bus.LAST_PIX = 0;
        bus.SQUEEZE = 0; bus.WORD_READY = 0;
        @(posedge clk); #1;
        chk_en = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("reset valid", bus.WORD_VALID, 1'b0);
        check("reset line_cnt", bus.LINE_CNT, 9'd0);

        // 40 alternating pixels, one line ending in LAST_PIX.
        log_q.delete();
        bus.WORD_READY = 1'b1;
        for (int i = 0; i < 40; i++) pix(bit'(i % 2 == 0), 1'b0, i == 39);
        wait_nlp("t1 next_last_pix");
        check("t1 words", log_q.size(), 2);
        check_word("t1 w0", 0, 32'h5555_5555, 32, 1'b0, 1'b0);
        check_word("t1 w1", 1, 32'h0000_0055, 8, 1'b1, 1'b1);
        check("t1 frame_ones", bus.FRAME_ONES, 17'd20);
        check("t1 line_cnt", bus.LINE_CNT, 9'd1);

        // 3 lines x 10 ones.
        log_q.delete();
        for (int i = 0; i < 30; i++) pix(1'b1, (i == 9) || (i == 19), i == 29);
        wait_nlp("t2 next_last_pix");
        check("t2 words", log_q.size(), 3);
        check_word("t2 w0", 0, 32'h3FF, 10, 1'b1, 1'b0);
        check_word("t2 w1", 1, 32'h3FF, 10, 1'b1, 1'b0);
        check_word("t2 w2", 2, 32'h3FF, 10, 1'b1, 1'b1);
        check("t2 line_cnt", bus.LINE_CNT, 9'd3);
        check("t2 frame_ones", bus.FRAME_ONES, 17'd30);

        // READY low, 5 lines of 4 pixels: fifth word (the frame's last) is dropped.
        log_q.delete();
        bus.WORD_READY = 1'b0;
        for (int k = 0; k < 5; k++)
            for (int j = 0; j < 4; j++)
                pix(bit'(((k + 1) >> j) & 1), (j == 3) && (k < 4), (j == 3) && (k == 4));
        @(negedge clk);
        check("t3 overflow", bus.OVERFLOW, 1'b1);
        check("t3 valid while full", bus.WORD_VALID, 1'b1);
        @(posedge clk); #1;
        bus.WORD_READY = 1'b1;
        wait_nlp("t3 next_last_pix");
        check("t3 words", log_q.size(), 4);
        for (int k = 0; k < 4; k++) check_word("t3 w", k, 32'(k + 1), 4, 1'b1, 1'b0);
        check("t3 frame_ones", bus.FRAME_ONES, 17'd7);
        check("t3 line_cnt", bus.LINE_CNT, 9'd5);

        reset_pulse();
        check("post-reset overflow", bus.OVERFLOW, 1'b0);

        // Pixels arriving in DRAIN are dropped; completion waits for the final pop.
        log_q.delete();
        bus.WORD_READY = 1'b0;
        pat = 8'h0B;
        for (int i = 0; i < 6; i++) pix(pat[i], 1'b0, i == 5);
        for (int i = 0; i < 10; i++) begin
            bus.DIN_VALID = (i % 3 == 1); bus.DIN = 1'b1;
            @(negedge clk);
            check("t4 nlp held low", bus.NEXT_LAST_PIX, 1'b0);
            @(posedge clk); #1;
        end
        bus.DIN_VALID = 1'b0; bus.DIN = 1'b0;
        check("t4 overflow", bus.OVERFLOW, 1'b1);
        bus.WORD_READY = 1'b1;
        wait_nlp("t4 next_last_pix");
        check_word("t4 w0", 0, 32'h0B, 6, 1'b1, 1'b1);
        check("t4 frame_ones", bus.FRAME_ONES, 17'd3);

        // SQUEEZE latched at the first pixel only.
        pat = 8'h3C;
        for (int i = 0; i < 8; i++) begin
            bus.SQUEEZE = (i < 3);
            pix(pat[i], 1'b0, i == 7);
            if (i == 5) check("t5 squeeze mid-frame", bus.SQUEEZE_LATCHED, 1'b1);
        end
        wait_nlp("t5a next_last_pix");
        check("t5 squeeze frame a", bus.SQUEEZE_LATCHED, 1'b1);
        pat = 8'hC3;
        for (int i = 0; i < 8; i++) begin
            bus.SQUEEZE = (i >= 2);
            pix(pat[i], 1'b0, i == 7);
        end
        wait_nlp("t5b next_last_pix");
        check("t5 squeeze frame b", bus.SQUEEZE_LATCHED, 1'b0);
        check("t5 frame_ones", bus.FRAME_ONES, 17'd4);
        bus.SQUEEZE = 1'b0;

        // Reset mid-frame after 17 pixels, then a fresh 8-pixel frame.
        for (int i = 0; i < 17; i++) pix(1'b1, 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("t6 rst valid", bus.WORD_VALID, 1'b0);
        check("t6 rst data", bus.WORD_DATA, 32'h0);
        check("t6 rst len", bus.WORD_LEN, 6'd0);
        check("t6 rst nlp", bus.NEXT_LAST_PIX, 1'b0);
        check("t6 rst squeeze", bus.SQUEEZE_LATCHED, 1'b0);
        check("t6 rst line_cnt", bus.LINE_CNT, 9'd0);
        check("t6 rst frame_ones", bus.FRAME_ONES, 17'd0);
        check("t6 rst overflow", bus.OVERFLOW, 1'b0);
        @(posedge clk); #1;
        log_q.delete();
        pat = 8'hA7;
        for (int i = 0; i < 8; i++) pix(pat[i], 1'b0, i == 7);
        wait_nlp("t6 next_last_pix");
        check("t6 words", log_q.size(), 1);
        check_word("t6 w0", 0, 32'hA7, 8, 1'b1, 1'b1);
        check("t6 frame_ones", bus.FRAME_ONES, 17'd5);

        repeat (3) @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/resize_bitpack_rx.md
Name: resize_bitpack_rx

Overview:
- Downstream receiver for the binary resize stream of the IPU pipeline. It is the consuming end of the DIN_VALID / LAST_IN_LINE / LAST_PIX / SQUEEZE / NEXT_LAST_PIX protocol.
- Packs accepted pixel bits into words, closes a word early at each line end, and buffers words in a small FWFT FIFO behind a VALID/READY port.
- Returns the NEXT_LAST_PIX completion pulse upstream once the frame's final word has been consumed.

Parameters:
- WORD_W, 32, packed word width in bits (2..32).
- FIFO_DEPTH, 4, word FIFO entries (power of 2, >=2).

Ports:
- CLK  in  1  clock.
- RST  in  1  synchronous reset, active-high.
- DIN_VALID  in  1  pixel strobe from the resize stage.
- DIN  in  1  binary pixel.
- LAST_IN_LINE  in  1  qualifies the current DIN as the last pixel of its line.
- LAST_PIX  in  1  qualifies the current DIN as the last pixel of the frame; it implies line end.
- SQUEEZE  in  1  upstream squeeze-mode level.
- NEXT_LAST_PIX  out  1  one-cycle pulse: the frame's final word has been accepted downstream.
- WORD_DATA  out  WORD_W  packed bits; bit i is the i-th pixel of the word.
- WORD_LEN  out  6  number of valid bits (1..WORD_W); unused upper bits are 0.
- WORD_LAST_LINE  out  1  word closes a line.
- WORD_LAST_FRAME  out  1  word closes the frame.
- WORD_VALID  out  1  FIFO head valid.
- WORD_READY  in  1  consumer accepts the head when WORD_VALID is also high.
- SQUEEZE_LATCHED  out  1  SQUEEZE sampled at the first pixel of the current frame.
- LINE_CNT  out  9  lines completed in the current frame.
- FRAME_ONES  out  17  count of 1-pixels in the last finished frame.
- OVERFLOW  out  1  sticky: a word or pixel was dropped.

Behaviour:
- Reset: every output 0. Packer empty, FIFO empty, counters 0, state IDLE.
- A pixel is accepted when DIN_VALID=1 and state is not DRAIN.
- Packing: a shift register holds pixel bits LSB-first, with a bit counter.
- A word closes when the bit counter reaches WORD_W, or on LAST_IN_LINE, or on LAST_PIX, whichever comes first.
- A closed word carries WORD_LEN = bits packed, WORD_LAST_LINE = LAST_IN_LINE|LAST_PIX, and WORD_LAST_FRAME = LAST_PIX.
- After a word closes, the packer restarts empty on the next pixel.
- Latency: a word that closes on the pixel accepted in cycle t is written to the FIFO at the edge ending t, and WORD_VALID is high in cycle t+1 if the FIFO was empty.
- FIFO is first-word-fall-through (FWFT). A pop occurs on WORD_VALID & WORD_READY.
- A simultaneous push and pop on a full FIFO succeeds.
- If a word closes while the FIFO is full and no pop is happening, the word is dropped, OVERFLOW is set, and the packer continues. If that dropped word had WORD_LAST_FRAME set, the state still goes to DRAIN, and DRAIN ends when the FIFO becomes empty.
- States:
  - IDLE -> RUN on the first accepted pixel. SQUEEZE_LATCHED <= SQUEEZE, LINE_CNT <= 0, internal ones counter <= DIN.
  - RUN: ones counter += DIN per pixel. LINE_CNT += 1 on each LAST_IN_LINE or LAST_PIX (saturates at 511).
  - RUN -> DRAIN on the pixel with LAST_PIX=1. FRAME_ONES <= final count, including that pixel.
  - A single-pixel frame (first pixel carries LAST_PIX) goes IDLE -> DRAIN directly, with FRAME_ONES = DIN.
  - DRAIN: DIN_VALID pixels are dropped and set OVERFLOW.
  - DRAIN exits on the pop of the WORD_LAST_FRAME entry (or on FIFO empty in the drop case). NEXT_LAST_PIX pulses high for exactly one cycle, the cycle after that pop, and the state returns to IDLE.
- LAST_IN_LINE or LAST_PIX with DIN_VALID=0 is ignored.
- Reset mid-frame: a synchronous RST discards FIFO contents and the partial word, returns to IDLE, and clears OVERFLOW. NEXT_LAST_PIX is not pulsed.
- WORD_DATA bits above WORD_LEN are 0.

Test Plan:
- WORD_W=32, one 40-pixel line of alternating 1,0 ending with LAST_PIX, READY=1 -> word0 0x55555555 LEN=32 no flags; word1 0x55 LEN=8 LAST_LINE=1 LAST_FRAME=1; NEXT_LAST_PIX pulses one cycle after word1 pops; FRAME_ONES=20; LINE_CNT=1.
- Frame of 3 lines x 10 pixels, all 1, READY=1 -> three words 0x3FF LEN=10, LAST_LINE on each, LAST_FRAME only on the third; LINE_CNT=3; FRAME_ONES=30.
- READY=0, 5 lines x 4 pixels with FIFO_DEPTH=4 -> 4 words buffered, 5th dropped, OVERFLOW=1; raising READY drains 4 words in order.
- After LAST_PIX, hold READY=0 for 10 cycles and send 3 DIN_VALID pixels -> pixels dropped, OVERFLOW=1, NEXT_LAST_PIX stays 0 until the final pop.
- SQUEEZE=1 at the first pixel, toggled mid-frame -> SQUEEZE_LATCHED stays 1 for the whole frame; the next frame with SQUEEZE=0 latches 0.
- RST pulse after 17 pixels -> all outputs 0 the next cycle; a new 8-pixel frame produces LEN=8 with correct data.
